stack_seq: RTL and testbench
============================

Name: stack_seq

Overview:
- Stack transfer sequencer: moves 1–3 bytes between processor registers (PCH/PCL/P/A) and the stack page in memory. It is the memory-side writer/reader for the register file's load and enable paths.
- Drives the external address bus, data-out and R/W. Writes the final stack pointer back for the S register's SB load. Used by PHA/PHP/PLA/PLP/BRK/IRQ/NMI/RTI/JSR/RTS sequencing.

Parameters:
- STACK_PAGE, 8'h01, high address byte for all stack accesses.

Ports:
- CLK  in  1  system clock, all state changes on rising edge
- RST  in  1  asynchronous active-high reset
- START  in  1  begin transfer; sampled only in IDLE
- OP  in  1  0 = push, 1 = pull
- COUNT  in  2  bytes to transfer, 1..3
- S_IN  in  8  current stack pointer, captured with START
- PUSH_DATA  in  24  push bytes {b2,b1,b0}, captured with START
- READY  in  1  memory ready; low stalls the sequencer
- DIN  in  8  memory read data, valid the cycle after a read address
- ADDR  out  16  memory address
- DOUT  out  8  memory write data
- RW  out  1  1 = read, 0 = write
- BUSY  out  1  high from the cycle after START until DONE inclusive
- DONE  out  1  one-cycle completion pulse
- S_OUT  out  8  updated stack pointer
- S_WE  out  1  load strobe for S, coincident with DONE
- PULL_DATA  out  24  pulled bytes {b2,b1,b0}, stable from DONE until next START

Behaviour:
- Reset (async, any state): state = IDLE; ADDR = 16'h0000; DOUT = 0; RW = 1; BUSY = DONE = S_WE = 0; S_OUT = 0; PULL_DATA = 0.
- Reset mid-transfer aborts the transfer with no S_WE and no further writes.
- States: IDLE, PUSH, PULL, PULL_TAIL, FIN.
- IDLE: RW = 1, BUSY = 0. On START:
  - Latch S_IN into sp, PUSH_DATA, OP and COUNT; clear PULL_DATA when OP = pull.
  - COUNT = 0: go to FIN with sp unchanged (no memory access).
  - Otherwise: push → PUSH, pull → PULL.
- PUSH, one byte per READY cycle:
  - Outputs: ADDR = {STACK_PAGE, sp}, RW = 0, DOUT = byte[remaining-1], so b2 goes first for COUNT = 3.
  - On a READY-high edge: sp <= sp-1 and remaining <= remaining-1.
  - When the last byte is accepted: go to FIN.
- PULL, pre-increment:
  - Outputs: ADDR = {STACK_PAGE, sp+1}, RW = 1.
  - On a READY-high edge: sp <= sp+1, issued <= issued+1.
  - DIN from the previous issued read is captured into byte[issued-1]; fill order is b0, b1, b2.
  - After the last address is issued: go to PULL_TAIL.
- PULL_TAIL: RW = 1, ADDR held. On a READY-high edge, capture the last DIN, then go to FIN.
- FIN: DONE = 1, S_WE = 1, S_OUT = sp for one cycle, then go to IDLE. This state is not affected by READY.
- Stall: READY low freezes state, sp, counters, ADDR, DOUT and RW. DIN is not sampled while stalled.
- Latency, with START sampled at edge 0 and READY held high:
  - Push n bytes: writes in cycles 1..n, DONE in cycle n+1.
  - Pull n bytes: addresses in cycles 1..n, captures at edges 2..n+1, DONE in cycle n+2.
- Wrap-around: sp arithmetic is modulo 256 and stays within STACK_PAGE (push at sp = 00 writes 0x0100, then sp = FF).
- Round trip: a push of n bytes followed by a pull of n bytes from the resulting S reproduces PUSH_DATA[8n-1:0] in PULL_DATA.
- START while BUSY is ignored.
- Unused PULL_DATA bytes read as 0.

Optional Feature:
- Macro: STACK_OVF_EN.
- Defined: adds output OVF (1 bit).
  - Sticky flag, set when a push decrements sp from 8'h00 or a pull increments it from 8'hFF.
  - Cleared by RST or by START.
  - Transfers still complete normally.
- Undefined: no OVF port; wrap is silent.

Decomposition:
- Package stack_pkg:
  - State enum (IDLE, PUSH, PULL, PULL_TAIL, FIN).
  - OP_PUSH = 1'b0, OP_PULL = 1'b1.
  - DEFAULT_STACK_PAGE = 8'h01.
  - Byte-count width constant CNT_W = 2.
- No sub-module: byte select and capture are small inline muxes.

Test Plan:
- Push 3: S_IN = FD, PUSH_DATA = 12_34_A5, READY = 1 → writes 12@01FD, 34@01FC, A5@01FB in cycles 1–3; DONE, S_WE, S_OUT = FA in cycle 4.
- Pull 3: S_IN = FA, memory 01FB = A5, 01FC = 34, 01FD = 12 (1-cycle read latency) → addresses 01FB–01FD; DONE in cycle 5; PULL_DATA = 12_34_A5; S_OUT = FD.
- Stall: push 2 with READY low for cycles 2–3 → ADDR, DOUT and RW held constant during the stall; second write completes after READY returns; DONE delayed by 2 cycles; S_OUT = S_IN-2.
- Wrap: push 1 at S_IN = 00 → write to 0100, S_OUT = FF (OVF = 1 with STACK_OVF_EN). Pull 1 at S_IN = FF → read 0100, S_OUT = 00.
- Edge cases, each run independently:
  - COUNT = 0 → DONE in cycle 1, S_OUT = S_IN, no RW = 0 cycle.
  - START asserted while BUSY → no effect on the transfer in progress.
- Reset mid-push: RST asserted after first write of push 3 → outputs immediately at reset values, no S_WE; next START behaves as from clean IDLE.

Source files
------------

// File: rtl/stack_pkg.sv
// Shared types and constants for the stack transfer sequencer.
package stack_pkg;

    typedef enum logic [2:0] {
        IDLE,
        PUSH,
        PULL,
        PULL_TAIL,
        FIN
    } state_t;

    localparam logic        OP_PUSH            = 1'b0;
    localparam logic        OP_PULL            = 1'b1;
    localparam logic [7:0]  DEFAULT_STACK_PAGE = 8'h01;
    localparam int unsigned CNT_W              = 2;

    // Select byte i of a {b2,b1,b0} word.
    function automatic logic [7:0] get_byte(input logic [23:0] d, input logic [CNT_W-1:0] i);
        case (i)
            2'd0:    get_byte = d[7:0];
            2'd1:    get_byte = d[15:8];
            default: get_byte = d[23:16];
        endcase
    endfunction

    // Replace byte i of a {b2,b1,b0} word.
    function automatic logic [23:0] put_byte(input logic [23:0] d, input logic [CNT_W-1:0] i,
                                             input logic [7:0] b);
        put_byte = d;
        case (i)
            2'd0:    put_byte[7:0]   = b;
            2'd1:    put_byte[15:8]  = b;
            default: put_byte[23:16] = b;
        endcase
    endfunction

endpackage

// File: rtl/stack_seq_if.sv
// Request/memory bus of the stack sequencer. OVF exists only with STACK_OVF_EN.
interface stack_seq_if;
    import stack_pkg::*;

    logic             START;
    logic             OP;
    logic [CNT_W-1:0] COUNT;
    logic [7:0]       S_IN;
    logic [23:0]      PUSH_DATA;
    logic             READY;
    logic [7:0]       DIN;
    logic [15:0]      ADDR;
    logic [7:0]       DOUT;
    logic             RW;
    logic             BUSY;
    logic             DONE;
    logic [7:0]       S_OUT;
    logic             S_WE;
    logic [23:0]      PULL_DATA;
`ifdef STACK_OVF_EN
    logic             OVF;
`endif

    modport master (
        output START, OP, COUNT, S_IN, PUSH_DATA, READY, DIN,
        input  ADDR, DOUT, RW, BUSY, DONE, S_OUT, S_WE, PULL_DATA
`ifdef STACK_OVF_EN
        , input OVF
`endif
    );

    modport slave (
        input  START, OP, COUNT, S_IN, PUSH_DATA, READY, DIN,
        output ADDR, DOUT, RW, BUSY, DONE, S_OUT, S_WE, PULL_DATA
`ifdef STACK_OVF_EN
        , output OVF
`endif
    );

endinterface

// File: rtl/stack_seq.sv
// Stack transfer sequencer: moves 1..3 bytes between registers and the stack page.
// Optional sticky wrap flag OVF is built when STACK_OVF_EN is defined.
module stack_seq
    import stack_pkg::*;
#(
    parameter logic [7:0] STACK_PAGE = DEFAULT_STACK_PAGE
) (
    input logic        CLK,
    input logic        RST,
    stack_seq_if.slave bus
);

    state_t           state_q, state_d;
    logic [7:0]       sp_q, sp_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;      // bytes remaining (push) / addresses issued (pull)
    logic [CNT_W-1:0] count_q, count_d;
    logic [23:0]      push_q, push_d;
    logic [23:0]      pull_q, pull_d;
    logic [CNT_W-1:0] idx;
`ifdef STACK_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // State and datapath registers; reset aborts any transfer in flight.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            sp_q    <= '0;
            cnt_q   <= '0;
            count_q <= '0;
            push_q  <= '0;
            pull_q  <= '0;
`ifdef STACK_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            sp_q    <= sp_d;
            cnt_q   <= cnt_d;
            count_q <= count_d;
            push_q  <= push_d;
            pull_q  <= pull_d;
`ifdef STACK_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    // Next-state, datapath update and bus outputs; READY low holds everything.
    always_comb begin
        state_d = state_q;
        sp_d    = sp_q;
        cnt_d   = cnt_q;
        count_d = count_q;
        push_d  = push_q;
        pull_d  = pull_q;
`ifdef STACK_OVF_EN
        ovf_d   = ovf_q;
`endif
        idx      = cnt_q - 2'd1;
        bus.ADDR = '0;
        bus.DOUT = '0;
        bus.RW   = 1'b1;
        bus.BUSY = (state_q != IDLE);
        bus.DONE = 1'b0;
        bus.S_WE = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.START) begin
                    sp_d    = bus.S_IN;
                    push_d  = bus.PUSH_DATA;
                    count_d = bus.COUNT;
                    cnt_d   = (bus.OP == OP_PUSH) ? bus.COUNT : '0;
`ifdef STACK_OVF_EN
                    ovf_d   = 1'b0;
`endif
                    if (bus.OP == OP_PULL) pull_d = '0;
                    if (bus.COUNT == '0)         state_d = FIN;
                    else if (bus.OP == OP_PUSH)  state_d = PUSH;
                    else                         state_d = PULL;
                end
            end
            PUSH: begin
                bus.ADDR = {STACK_PAGE, sp_q};
                bus.RW   = 1'b0;
                bus.DOUT = get_byte(push_q, idx);
                if (bus.READY) begin
                    sp_d  = sp_q - 8'd1;
                    cnt_d = cnt_q - 2'd1;
`ifdef STACK_OVF_EN
                    if (sp_q == 8'h00) ovf_d = 1'b1;
`endif
                    if (cnt_q == 2'd1) state_d = FIN;
                end
            end
            PULL: begin
                bus.ADDR = {STACK_PAGE, sp_q + 8'd1};
                if (bus.READY) begin
                    sp_d  = sp_q + 8'd1;
                    cnt_d = cnt_q + 2'd1;
`ifdef STACK_OVF_EN
                    if (sp_q == 8'hFF) ovf_d = 1'b1;
`endif
                    // DIN belongs to the address issued one accepted cycle earlier.
                    if (cnt_q != '0) pull_d = put_byte(pull_q, idx, bus.DIN);
                    if (cnt_q + 2'd1 == count_q) state_d = PULL_TAIL;
                end
            end
            PULL_TAIL: begin
                bus.ADDR = {STACK_PAGE, sp_q};
                if (bus.READY) begin
                    pull_d  = put_byte(pull_q, idx, bus.DIN);
                    state_d = FIN;
                end
            end
            FIN: begin
                bus.DONE = 1'b1;
                bus.S_WE = 1'b1;
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.S_OUT     = sp_q;
    assign bus.PULL_DATA = pull_q;
`ifdef STACK_OVF_EN
    assign bus.OVF       = ovf_q;
`endif

endmodule

// File: tb/tb_stack_seq.sv
// Self-checking bench for stack_seq with a byte-level stack-page memory model.
module tb_stack_seq;
    import stack_pkg::*;

    logic CLK = 1'b0;
    logic RST;
    always #5 CLK = ~CLK;

    stack_seq_if bus ();

    stack_seq #(.STACK_PAGE(8'h01)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus)
    );

    int unsigned n_chk  = 0;
    int unsigned n_fail = 0;

    logic [7:0]  smem    [256];   // memory seen by the DUT
    logic [7:0]  ref_mem [256];   // reference model's view of the stack page
    logic [23:0] wlog [$];        // {addr, data} of every accepted write

    // Stack-page memory: writes and reads accepted only when READY, 1-cycle read data.
    always @(posedge CLK) begin
        if (RST) begin
            for (int i = 0; i < 256; i++) smem[i] <= 8'(i) ^ 8'h5A;
        end else if (bus.READY) begin
            if (!bus.RW) begin
                smem[bus.ADDR[7:0]] <= bus.DOUT;
                wlog.push_back({bus.ADDR, bus.DOUT});
            end
            bus.DIN <= smem[bus.ADDR[7:0]];
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic init_ref();
        for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h5A;
    endtask

    // One transfer: model predicts writes, pulled bytes, S and latency; bench checks all.
    task automatic run_xfer(input string name, input logic op, input logic [1:0] cnt,
                            input logic [7:0] s_in, input logic [23:0] pd, input bit rnd,
                            input logic [31:0] lowmask, input bit poke,
                            output logic [23:0] got_pull);
        logic [7:0]  sp;
        logic [23:0] exp_w [$];
        logic [23:0] exp_pull;
        logic        ovf_exp;
        int          base, stalls, done_cyc, wstart, nw;
        logic [15:0] p_addr;
        logic [7:0]  p_dout;
        logic        p_rw, prev_stall, rdy, low;

        sp = s_in; exp_pull = '0; ovf_exp = 1'b0;
        if (op == OP_PUSH) begin
            for (int k = int'(cnt) - 1; k >= 0; k--) begin
                exp_w.push_back({8'h01, sp, pd[8*k +: 8]});
                ref_mem[sp] = pd[8*k +: 8];
                if (sp == 8'h00) ovf_exp = 1'b1;
                sp = sp - 8'd1;
            end
        end else begin
            for (int k = 0; k < int'(cnt); k++) begin
                if (sp == 8'hFF) ovf_exp = 1'b1;
                sp = sp + 8'd1;
                exp_pull[8*k +: 8] = ref_mem[sp];
            end
        end
        if (cnt == 2'd0)          base = 1;
        else if (op == OP_PUSH)   base = int'(cnt) + 1;
        else                      base = int'(cnt) + 2;

        stalls = 0; done_cyc = -1; prev_stall = 1'b0;
        p_addr = '0; p_dout = '0; p_rw = 1'b1;
        @(negedge CLK);
        wstart = wlog.size();
        bus.START = 1'b1; bus.OP = op; bus.COUNT = cnt; bus.S_IN = s_in;
        bus.PUSH_DATA = pd; bus.READY = 1'b1;

        for (int c = 1; c <= 60; c++) begin
            @(negedge CLK);
            if (c == 1) begin
                bus.START = poke;
                if (poke) begin
                    bus.OP = ~op; bus.COUNT = 2'd3; bus.S_IN = ~s_in; bus.PUSH_DATA = ~pd;
                end
            end
            if (c == 2) bus.START = 1'b0;
            n_chk++;
            if (bus.BUSY !== 1'b1) begin
                n_fail++; $display("FAIL %s busy c=%0d got %b exp 1", name, c, bus.BUSY);
            end
            if (prev_stall) begin
                n_chk++;
                if ({bus.ADDR, bus.DOUT, bus.RW} !== {p_addr, p_dout, p_rw}) begin
                    n_fail++;
                    $display("FAIL %s stall_hold c=%0d got %h/%h/%b exp %h/%h/%b",
                             name, c, bus.ADDR, bus.DOUT, bus.RW, p_addr, p_dout, p_rw);
                end
            end
            if (bus.DONE === 1'b1) begin
                done_cyc = c;
                n_chk++;
                if ({bus.S_WE, bus.S_OUT} !== {1'b1, sp}) begin
                    n_fail++;
                    $display("FAIL %s s_out got we=%b s=%h exp we=1 s=%h", name, bus.S_WE, bus.S_OUT, sp);
                end
`ifdef STACK_OVF_EN
                n_chk++;
                if (bus.OVF !== ovf_exp) begin
                    n_fail++; $display("FAIL %s ovf got %b exp %b", name, bus.OVF, ovf_exp);
                end
`endif
                break;
            end
            n_chk++;
            if (bus.S_WE !== 1'b0) begin
                n_fail++; $display("FAIL %s s_we_early c=%0d got %b exp 0", name, c, bus.S_WE);
            end
            p_addr = bus.ADDR; p_dout = bus.DOUT; p_rw = bus.RW;
            low = 1'b0;
            if (c < 32) low = lowmask[c];
            rdy = rnd ? ($urandom_range(0, 3) != 0) : !low;
            bus.READY = rdy;
            prev_stall = !rdy;
            if (!rdy) stalls++;
        end
        bus.START = 1'b0;
        bus.READY = 1'b1;

        n_chk++;
        if (done_cyc != base + stalls) begin
            n_fail++; $display("FAIL %s done_cycle got %0d exp %0d", name, done_cyc, base + stalls);
        end
        nw = wlog.size() - wstart;
        n_chk++;
        if (nw != exp_w.size()) begin
            n_fail++; $display("FAIL %s write_count got %0d exp %0d", name, nw, exp_w.size());
        end else begin
            for (int i = 0; i < exp_w.size(); i++) begin
                n_chk++;
                if (wlog[wstart + i] !== exp_w[i]) begin
                    n_fail++;
                    $display("FAIL %s write%0d got %h exp %h", name, i, wlog[wstart + i], exp_w[i]);
                end
            end
        end
        if (op == OP_PULL) begin
            n_chk++;
            if (bus.PULL_DATA !== exp_pull) begin
                n_fail++; $display("FAIL %s pull_data got %h exp %h", name, bus.PULL_DATA, exp_pull);
            end
        end
        @(negedge CLK);
        n_chk++;
        if ({bus.BUSY, bus.DONE, bus.S_WE} !== 3'b000) begin
            n_fail++; $display("FAIL %s idle_after got %b exp 000", name, {bus.BUSY, bus.DONE, bus.S_WE});
        end
        if (op == OP_PULL) begin
            n_chk++;
            if (bus.PULL_DATA !== exp_pull) begin
                n_fail++; $display("FAIL %s pull_hold got %h exp %h", name, bus.PULL_DATA, exp_pull);
            end
        end
        got_pull = bus.PULL_DATA;
    endtask

    task automatic test_reset();
        bus.START = 1'b0; bus.OP = OP_PUSH; bus.COUNT = '0; bus.S_IN = '0;
        bus.PUSH_DATA = '0; bus.READY = 1'b1;
        RST = 1'b1;
        init_ref();
        #1;
        n_chk++;
        if ({bus.ADDR, bus.DOUT, bus.RW, bus.BUSY, bus.DONE, bus.S_WE, bus.S_OUT, bus.PULL_DATA}
            !== {16'h0000, 8'h00, 1'b1, 3'b000, 8'h00, 24'h000000}) begin
            n_fail++;
            $display("FAIL reset_values got addr=%h dout=%h rw=%b busy=%b done=%b we=%b s=%h pd=%h",
                     bus.ADDR, bus.DOUT, bus.RW, bus.BUSY, bus.DONE, bus.S_WE, bus.S_OUT, bus.PULL_DATA);
        end
        @(negedge CLK); @(negedge CLK);
        RST = 1'b0;
    endtask

    task automatic test_push_pull3();
        logic [23:0] got;
        run_xfer("push3", OP_PUSH, 2'd3, 8'hFD, 24'h1234A5, 1'b0, '0, 1'b0, got);
        run_xfer("pull3", OP_PULL, 2'd3, 8'hFA, 24'h0, 1'b0, '0, 1'b0, got);
        n_chk++;
        if (got !== 24'h1234A5) begin
            n_fail++; $display("FAIL pull3_value got %h exp 1234a5", got);
        end
    endtask

    task automatic test_stall();
        logic [23:0] got;
        run_xfer("stall_push2", OP_PUSH, 2'd2, 8'h40, 24'h00BEEF, 1'b0, 32'h0000_000C, 1'b0, got);
        run_xfer("stall_pull3", OP_PULL, 2'd3, 8'h3E, 24'h0, 1'b0, 32'h0000_0014, 1'b0, got);
    endtask

    task automatic test_wrap();
        logic [23:0] got;
        run_xfer("wrap_push", OP_PUSH, 2'd1, 8'h00, 24'h0000C3, 1'b0, '0, 1'b0, got);
        run_xfer("wrap_pull", OP_PULL, 2'd1, 8'hFF, 24'h0, 1'b0, '0, 1'b0, got);
        n_chk++;
        if (got !== 24'h0000C3) begin
            n_fail++; $display("FAIL wrap_value got %h exp 0000c3", got);
        end
    endtask

    task automatic test_count0();
        logic [23:0] got;
        run_xfer("count0_push", OP_PUSH, 2'd0, 8'h77, 24'hABCDEF, 1'b0, '0, 1'b0, got);
        run_xfer("count0_pull", OP_PULL, 2'd0, 8'h55, 24'h0, 1'b0, '0, 1'b0, got);
    endtask

    task automatic test_start_while_busy();
        logic [23:0] got;
        run_xfer("busy_start", OP_PUSH, 2'd2, 8'h90, 24'h005A6B, 1'b0, '0, 1'b1, got);
    endtask

    task automatic test_reset_mid_push();
        int          wstart;
        logic [23:0] got;
        @(negedge CLK);
        wstart = wlog.size();
        bus.START = 1'b1; bus.OP = OP_PUSH; bus.COUNT = 2'd3; bus.S_IN = 8'h80;
        bus.PUSH_DATA = 24'hC1D2E3; bus.READY = 1'b1;
        @(negedge CLK);
        bus.START = 1'b0;
        @(negedge CLK);
        n_chk++;
        if (wlog.size() != wstart + 1 || wlog[wlog.size() - 1] !== 24'h0180C1) begin
            n_fail++; $display("FAIL rst_mid_first_write got n=%0d exp n=1 data 0180c1", wlog.size() - wstart);
        end
        RST = 1'b1;
        #1;
        n_chk++;
        if ({bus.ADDR, bus.DOUT, bus.RW, bus.BUSY, bus.DONE, bus.S_WE, bus.S_OUT}
            !== {16'h0000, 8'h00, 1'b1, 3'b000, 8'h00}) begin
            n_fail++;
            $display("FAIL rst_mid_values got addr=%h dout=%h rw=%b busy=%b done=%b we=%b s=%h",
                     bus.ADDR, bus.DOUT, bus.RW, bus.BUSY, bus.DONE, bus.S_WE, bus.S_OUT);
        end
        @(negedge CLK); @(negedge CLK);
        RST = 1'b0;
        init_ref();
        @(negedge CLK);
        n_chk++;
        if (wlog.size() != wstart + 1 || bus.S_WE !== 1'b0) begin
            n_fail++; $display("FAIL rst_mid_abort got writes=%0d we=%b exp writes=1 we=0",
                               wlog.size() - wstart, bus.S_WE);
        end
        run_xfer("after_reset", OP_PUSH, 2'd1, 8'h20, 24'h000099, 1'b0, '0, 1'b0, got);
    endtask

    task automatic test_random();
        logic [23:0] got, pd;
        logic [7:0]  s;
        logic [1:0]  n;
        for (int it = 0; it < 24; it++) begin
            case ($urandom_range(0, 4))
                0:       s = 8'h00;
                1:       s = 8'hFF;
                2:       s = 8'h01;
                default: s = 8'($urandom);
            endcase
            n  = 2'($urandom_range(0, 3));
            pd = 24'($urandom);
            // Push then pull back from the resulting S: round trip must reproduce the data.
            run_xfer("rand_push", OP_PUSH, n, s, pd, 1'b1, '0, 1'b0, got);
            run_xfer("rand_pull", OP_PULL, n, s - 8'(n), 24'h0, 1'b1, '0, 1'b0, got);
            n_chk++;
            if (got !== (pd & ((24'h1 << (8 * int'(n))) - 24'h1))) begin
                n_fail++; $display("FAIL round_trip n=%0d got %h exp %h", n, got, pd);
            end
            if ($urandom_range(0, 1) == 1)
                run_xfer("rand_misc", 1'($urandom), 2'($urandom), 8'($urandom), 24'($urandom),
                         1'b1, '0, 1'b0, got);
        end
    endtask

    initial begin
        test_reset();
        test_push_pull3();
        test_stall();
        test_wrap();
        test_count0();
        test_start_while_busy();
        test_reset_mid_push();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
